// File: rtl/wb_gpio.sv
// -----------------------------------------------------------------------------
// wb_gpio -- parametrised Wishbone classic GPIO slave.
//
// Provides WIDTH bidirectional pins with per-bit direction, a two-flop input
// synchroniser, optional debounce filter, rise/fall edge detection and a
// maskable level interrupt. Pad tristating (gpio_oe ? gpio_o : 'z) is done at
// SoC top; this block only produces the data and enable vectors.
//
// Optional feature macro: GPIO_DEBOUNCE_EN
//   defined   -> per-bit debounce counter; a pin must differ from the filtered
//                value for DEBOUNCE_CYCLES consecutive cycles before in_q
//                follows it.
//   undefined -> in_q simply follows the synchroniser output every cycle.
//
// Register map (word offset, adr[4:2]):
//   0x00 DATA_IN    RO   filtered synchronised inputs
//   0x04 DATA_OUT   RW   drives gpio_o
//   0x08 DIR        RW   drives gpio_oe
//   0x0C IRQ_RISE   RW   rising-edge event enables
//   0x10 IRQ_FALL   RW   falling-edge event enables
//   0x14 IRQ_STATUS W1C  latched events
//   0x18 IRQ_MASK   RW   interrupt mask
//   0x1C reserved        reads 0, writes ignored
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   wb_adr     in   [31:0] byte address (only [4:2] decoded)
//   wb_dat_m   in   [31:0] write data from master
//   wb_dat_s   out  [31:0] read data (0 when ack is low)
//   wb_sel     in   [3:0]  byte enables
//   wb_we      in   write enable
//   wb_cyc     in   bus cycle
//   wb_stb     in   strobe
//   wb_ack     out  one-cycle acknowledge
//   wb_err     out  tied 0
//   wb_stall   out  tied 0
//   gpio_i     in   [WIDTH-1:0] asynchronous pin inputs
//   gpio_o     out  [WIDTH-1:0] output data
//   gpio_oe    out  [WIDTH-1:0] per-bit output enable (1 = drive)
//   irq        out  level interrupt
// -----------------------------------------------------------------------------
module wb_gpio #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      wb_adr,
    input  logic [31:0]      wb_dat_m,
    output logic [31:0]      wb_dat_s,
    input  logic [3:0]       wb_sel,
    input  logic             wb_we,
    input  logic             wb_cyc,
    input  logic             wb_stb,
    output logic             wb_ack,
    output logic             wb_err,
    output logic             wb_stall,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    typedef enum logic [2:0] {
        REG_DATA_IN    = 3'd0,
        REG_DATA_OUT   = 3'd1,
        REG_DIR        = 3'd2,
        REG_IRQ_RISE   = 3'd3,
        REG_IRQ_FALL   = 3'd4,
        REG_IRQ_STATUS = 3'd5,
        REG_IRQ_MASK   = 3'd6,
        REG_RESERVED   = 3'd7
    } reg_sel_e;

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irq_rise;
    logic [WIDTH-1:0] irq_fall;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] irq_status;

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] in_q;
    logic [WIDTH-1:0] in_prev;

    logic [31:0]      byte_mask;
    logic [31:0]      wr_bits;
    logic [WIDTH-1:0] wr_keep;
    logic [WIDTH-1:0] wr_val;
    logic             wr_en;
    reg_sel_e         reg_sel;
    logic [WIDTH-1:0] rd_bits;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] evt_bits;
    logic [WIDTH-1:0] w1c_bits;

    assign wb_err   = 1'b0;
    assign wb_stall = 1'b0;

    // Expand the byte enables into a bit mask; bits above WIDTH are dropped,
    // which is what makes writes to [31:WIDTH] ignored.
    always_comb begin
        byte_mask = '0;
        for (int b = 0; b < 4; b++) begin
            byte_mask[8*b +: 8] = {8{wb_sel[b]}};
        end
    end

    assign wr_bits = wb_dat_m & byte_mask;
    assign wr_keep = byte_mask[WIDTH-1:0];
    assign wr_val  = wr_bits[WIDTH-1:0];
    assign reg_sel = reg_sel_e'(wb_adr[4:2]);

    // A write commits on the edge that ends the ack cycle, and only if the
    // master is still holding the cycle; a dropped cyc aborts it.
    assign wr_en = wb_ack & wb_cyc & wb_stb & wb_we;

    // Address bits outside [4:2] and write data above WIDTH are ignored.
    logic unused_ok;
    assign unused_ok = &{1'b0, wb_adr[31:5], wb_adr[1:0], wr_bits, byte_mask};

    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_val);
        return (old_val & ~wr_keep) | wr_val;
    endfunction

    // Ack is a single-cycle pulse: the ~wb_ack term forces a gap cycle so a
    // held cyc/stb yields at most one transfer every two cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack <= 1'b0;
        end else begin
            wb_ack <= wb_cyc & wb_stb & ~wb_ack;
        end
    end

    // Software-visible RW registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            dir      <= '0;
            irq_rise <= '0;
            irq_fall <= '0;
            irq_mask <= '0;
        end else if (wr_en) begin
            case (reg_sel)
                REG_DATA_OUT: data_out <= merge(data_out);
                REG_DIR:      dir      <= merge(dir);
                REG_IRQ_RISE: irq_rise <= merge(irq_rise);
                REG_IRQ_FALL: irq_fall <= merge(irq_fall);
                REG_IRQ_MASK: irq_mask <= merge(irq_mask);
                default: ;
            endcase
        end
    end

    // Two-flop synchroniser plus the previous filtered value for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            in_prev <= '0;
        end else begin
            s1      <= gpio_i;
            s2      <= s1;
            in_prev <= in_q;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] db_cnt [WIDTH];

    // Per-bit debounce: the counter runs while the synchronised pin disagrees
    // with in_q. The cycle on which it would reach DEBOUNCE_CYCLES is the one
    // that transfers the new level, so a disagreement lasting fewer cycles
    // never reaches in_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s2[i] == in_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    in_q[i]   <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    // No filtering: in_q is simply a third register stage after the synchroniser.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q <= '0;
        end else begin
            in_q <= s2;
        end
    end
`endif

    assign rise     = in_q & ~in_prev;
    assign fall     = ~in_q & in_prev;
    assign evt_bits = (rise & irq_rise) | (fall & irq_fall);
    assign w1c_bits = (wr_en && reg_sel == REG_IRQ_STATUS) ? wr_val : '0;

    // Events are OR-ed in after the clear so a new event always survives a
    // simultaneous write-one-to-clear of the same bit. The mask does not
    // gate latching, only the interrupt output.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_status <= '0;
        end else begin
            irq_status <= (irq_status & ~w1c_bits) | evt_bits;
        end
    end

    always_comb begin
        rd_bits = '0;
        case (reg_sel)
            REG_DATA_IN:    rd_bits = in_q;
            REG_DATA_OUT:   rd_bits = data_out;
            REG_DIR:        rd_bits = dir;
            REG_IRQ_RISE:   rd_bits = irq_rise;
            REG_IRQ_FALL:   rd_bits = irq_fall;
            REG_IRQ_STATUS: rd_bits = irq_status;
            REG_IRQ_MASK:   rd_bits = irq_mask;
            default:        rd_bits = '0;
        endcase
    end

    assign wb_dat_s = wb_ack ? 32'(rd_bits) : 32'd0;
    assign gpio_o   = data_out;
    assign gpio_oe  = dir;
    assign irq      = |(irq_status & irq_mask);

endmodule

// File: tb/tb_wb_gpio.sv
// -----------------------------------------------------------------------------
// tb_wb_gpio -- self-checking bench for wb_gpio.
//
// Two instances share the Wishbone request signals: dut (WIDTH=8) and dut32
// (WIDTH=32), so byte-select and upper-bit behaviour is seen at both widths.
// A table of register accesses covers the register map; hand-written
// sequences cover edge-detect timing, W1C vs. event collision, mask behaviour,
// reset mid-transfer and (with GPIO_DEBOUNCE_EN) the debounce filter.
// -----------------------------------------------------------------------------
module tb_wb_gpio;

    localparam int DB = 16;
`ifdef GPIO_DEBOUNCE_EN
    localparam int IN_LAT = 2 + DB;
`else
    localparam int IN_LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_m;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic [7:0]  gpio_i;
    logic [31:0] gpio_i32;

    logic [31:0] dat_s8;
    logic        ack8;
    logic        err8;
    logic        stall8;
    logic [7:0]  gpio_o8;
    logic [7:0]  gpio_oe8;
    logic        irq8;

    logic [31:0] dat_s32;
    logic        ack32;
    logic        err32;
    logic        stall32;
    logic [31:0] gpio_o32;
    logic [31:0] gpio_oe32;
    logic        irq32;

    int checks   = 0;
    int failures = 0;

    assign gpio_i32 = {24'h0, gpio_i};

    always #5 clk = ~clk;

    wb_gpio #(.WIDTH(8), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst(rst),
        .wb_adr(wb_adr), .wb_dat_m(wb_dat_m), .wb_dat_s(dat_s8), .wb_sel(wb_sel),
        .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_ack(ack8),
        .wb_err(err8), .wb_stall(stall8),
        .gpio_i(gpio_i), .gpio_o(gpio_o8), .gpio_oe(gpio_oe8), .irq(irq8)
    );

    wb_gpio #(.WIDTH(32), .DEBOUNCE_CYCLES(DB)) dut32 (
        .clk(clk), .rst(rst),
        .wb_adr(wb_adr), .wb_dat_m(wb_dat_m), .wb_dat_s(dat_s32), .wb_sel(wb_sel),
        .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_ack(ack32),
        .wb_err(err32), .wb_stall(stall32),
        .gpio_i(gpio_i32), .gpio_o(gpio_o32), .gpio_oe(gpio_oe32), .irq(irq32)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] adr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [31:0] exp8;
        logic [31:0] exp32;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // One Wishbone access, started at the current time (caller sits just after
    // a rising edge). Holds cyc/stb through the commit edge, then checks the
    // ack pulse was exactly one cycle long and issued on the first edge.
    task automatic applyStimulus(input logic [31:0] adr, input logic [31:0] data,
                                 input logic [3:0] sel, input logic we,
                                 output logic [31:0] rd8, output logic [31:0] rd32);
        bit got = 0;
        int lat = 0;
        rd8  = '0;
        rd32 = '0;
        wb_adr   = adr;
        wb_dat_m = data;
        wb_sel   = sel;
        wb_we    = we;
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ack8) begin
                got  = 1;
                lat  = i;
                rd8  = dat_s8;
                rd32 = dat_s32;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL ack_timeout adr=0x%08h actual=no_ack required=ack", adr);
        end else begin
            checkOutput("ack_latency", lat, 0);
            checkOutput("ack32_with_ack8", {31'd0, ack32}, 32'd1);
            @(posedge clk);
            #1;
            checkOutput("ack_pulse_width", {31'd0, ack8}, 32'd0);
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic wbWrite(input logic [31:0] adr, input logic [31:0] data);
        logic [31:0] d8;
        logic [31:0] d32;
        applyStimulus(adr, data, 4'hF, 1'b1, d8, d32);
    endtask

    task automatic wbRead(input string name, input logic [31:0] adr,
                          input logic [31:0] exp8, input logic [31:0] exp32);
        logic [31:0] d8;
        logic [31:0] d32;
        applyStimulus(adr, 32'd0, 4'hF, 1'b0, d8, d32);
        checkOutput(name, d8, exp8);
        checkOutput({name, "_w32"}, d32, exp32);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] d8;
        logic [31:0] d32;

        // Register-map vectors, applied in order.
        vecs.push_back('{"rst_data_in",   0, 32'h00, 32'h0,        4'hF, 32'h0,  32'h0});
        vecs.push_back('{"rst_data_out",  0, 32'h04, 32'h0,        4'hF, 32'h0,  32'h0});
        vecs.push_back('{"rst_dir",       0, 32'h08, 32'h0,        4'hF, 32'h0,  32'h0});
        vecs.push_back('{"rst_irq_rise",  0, 32'h0C, 32'h0,        4'hF, 32'h0,  32'h0});
        vecs.push_back('{"rst_irq_fall",  0, 32'h10, 32'h0,        4'hF, 32'h0,  32'h0});
        vecs.push_back('{"rst_status",    0, 32'h14, 32'h0,        4'hF, 32'h0,  32'h0});
        vecs.push_back('{"rst_mask",      0, 32'h18, 32'h0,        4'hF, 32'h0,  32'h0});
        vecs.push_back('{"rst_reserved",  0, 32'h1C, 32'h0,        4'hF, 32'h0,  32'h0});
        vecs.push_back('{"wr_data_out",   1, 32'h04, 32'hA5,       4'hF, 32'h0,  32'h0});
        vecs.push_back('{"wr_dir",        1, 32'h08, 32'hF0,       4'hF, 32'h0,  32'h0});
        vecs.push_back('{"rd_data_out",   0, 32'h04, 32'h0,        4'hF, 32'hA5, 32'hA5});
        vecs.push_back('{"rd_dir",        0, 32'h08, 32'h0,        4'hF, 32'hF0, 32'hF0});
        vecs.push_back('{"wr_reserved",   1, 32'h1C, 32'hFFFFFFFF, 4'hF, 32'h0,  32'h0});
        vecs.push_back('{"rd_reserved",   0, 32'h1C, 32'h0,        4'hF, 32'h0,  32'h0});
        vecs.push_back('{"wr_data_in_ro", 1, 32'h00, 32'hFF,       4'hF, 32'h0,  32'h0});
        vecs.push_back('{"rd_data_in_ro", 0, 32'h00, 32'h0,        4'hF, 32'h0,  32'h0});
        vecs.push_back('{"wr_mask_hi",    1, 32'h18, 32'hFFFFFF00, 4'hF, 32'h0,  32'h0});
        vecs.push_back('{"rd_mask_hi",    0, 32'h18, 32'h0,        4'hF, 32'h0,  32'hFFFFFF00});
        vecs.push_back('{"wr_rise_sel0",  1, 32'h0C, 32'h12345677, 4'h1, 32'h0,  32'h0});
        vecs.push_back('{"rd_rise_sel0",  0, 32'h0C, 32'h0,        4'hF, 32'h77, 32'h77});
        vecs.push_back('{"wr_rise_sel1",  1, 32'h0C, 32'hFFFFFFFF, 4'h2, 32'h0,  32'h0});
        vecs.push_back('{"rd_rise_sel1",  0, 32'h0C, 32'h0,        4'hF, 32'h77, 32'hFF77});
        vecs.push_back('{"clr_rise",      1, 32'h0C, 32'h0,        4'hF, 32'h0,  32'h0});
        vecs.push_back('{"clr_mask",      1, 32'h18, 32'h0,        4'hF, 32'h0,  32'h0});
        vecs.push_back('{"wr_beef_sel0",  1, 32'h04, 32'hDEADBEEF, 4'h1, 32'h0,  32'h0});
        vecs.push_back('{"rd_beef_sel0",  0, 32'h04, 32'h0,        4'hF, 32'hEF, 32'hEF});
        vecs.push_back('{"wr_beef_all",   1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0,  32'h0});
        vecs.push_back('{"rd_beef_all",   0, 32'h04, 32'h0,        4'hF, 32'hEF, 32'hDEADBEEF});
        vecs.push_back('{"wr_restore",    1, 32'h04, 32'hA5,       4'hF, 32'h0,  32'h0});
        vecs.push_back('{"rd_upper_adr",  0, 32'h104, 32'h0,       4'hF, 32'hA5, 32'hA5});

        rst      = 1'b1;
        wb_adr   = '0;
        wb_dat_m = '0;
        wb_sel   = '0;
        wb_we    = 1'b0;
        wb_cyc   = 1'b0;
        wb_stb   = 1'b0;
        gpio_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset_ack",     {31'd0, ack8}, 32'd0);
        checkOutput("reset_gpio_o",  {24'd0, gpio_o8}, 32'd0);
        checkOutput("reset_gpio_oe", {24'd0, gpio_oe8}, 32'd0);
        checkOutput("reset_irq",     {31'd0, irq8}, 32'd0);
        checkOutput("err_tied",      {30'd0, err8, err32}, 32'd0);
        checkOutput("stall_tied",    {30'd0, stall8, stall32}, 32'd0);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].adr, vecs[k].data, vecs[k].sel, vecs[k].we, d8, d32);
            if (!vecs[k].we) begin
                checkOutput(vecs[k].name, d8, vecs[k].exp8);
                checkOutput({vecs[k].name, "_w32"}, d32, vecs[k].exp32);
            end
        end

        checkOutput("pin_gpio_o",    {24'd0, gpio_o8}, 32'hA5);
        checkOutput("pin_gpio_oe",   {24'd0, gpio_oe8}, 32'hF0);
        checkOutput("pin_gpio_o32",  gpio_o32, 32'hA5);
        checkOutput("pin_gpio_oe32", gpio_oe32, 32'hF0);
        checkOutput("irq_idle",      {30'd0, irq8, irq32}, 32'd0);

        // Rising edge on bit 0: STATUS/irq appear one edge after in_q updates.
        wbWrite(32'h0C, 32'h01);
        wbWrite(32'h18, 32'h01);
        @(posedge clk);
        #1;
        gpio_i[0] = 1'b1;
        repeat (IN_LAT) @(posedge clk);
        #1;
        checkOutput("irq_before_event", {31'd0, irq8}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("irq_rise_event", {31'd0, irq8}, 32'd1);
        checkOutput("irq32_rise_event", {31'd0, irq32}, 32'd1);
        wbRead("status_rise", 32'h14, 32'h01, 32'h01);
        wbRead("data_in_bit0", 32'h00, 32'h01, 32'h01);
        wbWrite(32'h14, 32'h01);
        checkOutput("irq_after_w1c", {31'd0, irq8}, 32'd0);
        wbRead("status_after_w1c", 32'h14, 32'h00, 32'h00);

        // Falling edge on bit 3 colliding with a W1C of bit 3.
        wbWrite(32'h10, 32'h08);
        @(posedge clk);
        #1;
        gpio_i[3] = 1'b1;
        repeat (IN_LAT + 3) @(posedge clk);
        #1;
        gpio_i[3] = 1'b0;
        repeat (IN_LAT + 3) @(posedge clk);
        #1;
        wbRead("status_fall", 32'h14, 32'h08, 32'h08);
        gpio_i[3] = 1'b1;
        repeat (IN_LAT + 3) @(posedge clk);
        #1;
        gpio_i[3] = 1'b0;
        repeat (IN_LAT - 1) @(posedge clk);
        #1;
        wbWrite(32'h14, 32'h08);
        wbRead("status_event_beats_w1c", 32'h14, 32'h08, 32'h08);
        checkOutput("irq_masked_event", {31'd0, irq8}, 32'd0);
        wbWrite(32'h18, 32'h09);
        checkOutput("irq_after_unmask", {31'd0, irq8}, 32'd1);

        // Reset in the middle of a write: ack drops, write is lost.
        wb_adr   = 32'h04;
        wb_dat_m = 32'h55;
        wb_sel   = 4'hF;
        wb_we    = 1'b1;
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midxfer_ack_seen", {31'd0, ack8}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midxfer_ack_dropped", {31'd0, ack8}, 32'd0);
        checkOutput("midxfer_gpio_o", {24'd0, gpio_o8}, 32'd0);
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        rst    = 1'b0;
        checkOutput("midxfer_irq", {31'd0, irq8}, 32'd0);
        repeat (IN_LAT + 10) @(posedge clk);
        #1;
        wbRead("post_reset_data_in", 32'h00, 32'h01, 32'h01);
        wbRead("post_reset_data_out", 32'h04, 32'h00, 32'h00);
        wbRead("post_reset_status", 32'h14, 32'h00, 32'h00);

`ifdef GPIO_DEBOUNCE_EN
        // Short glitch is filtered; long pulse passes and latches a rise.
        wbWrite(32'h0C, 32'h02);
        gpio_i[1] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        gpio_i[1] = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        wbRead("db_glitch_data_in", 32'h00, 32'h01, 32'h01);
        wbRead("db_glitch_status", 32'h14, 32'h00, 32'h00);
        gpio_i[1] = 1'b1;
        repeat (19) @(posedge clk);
        #1;
        wbRead("db_pulse_data_in", 32'h00, 32'h03, 32'h03);
        gpio_i[1] = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        wbRead("db_pulse_status", 32'h14, 32'h02, 32'h02);
        wbRead("db_pulse_released", 32'h00, 32'h01, 32'h01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
